// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: ramps one PWM channel's DUTY register between START and END, sharing the PWM port with the CPU.
module pwm_ramp_ctrl #(
  parameter logic [31:0] RAMP_BASE_ADDR = 32'h40003100,
  parameter logic [31:0] PWM_BASE_ADDR  = 32'h40003000,
  parameter int          PWM_NUM        = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cpu_mem_addr,
  input  logic [31:0] cpu_mem_wdata,
  input  logic        cpu_mem_we,
  input  logic        cpu_mem_re,
  output logic [31:0] cpu_mem_rdata,
  output logic [31:0] pwm_mem_addr,
  output logic [31:0] pwm_mem_wdata,
  output logic        pwm_mem_we,
  output logic        pwm_mem_re,
  input  logic [31:0] pwm_mem_rdata,
  output logic        done_irq
);
  typedef enum logic [1:0] {IDLE, WRITE, WAIT, DONE} state_t;
  localparam logic [4:0] CH_LIM = 5'(PWM_NUM);
  state_t      r_state;
  logic        r_en, r_bounce, r_dir, r_to_end, r_done, r_done_irq;
  logic [3:0]  r_ch;
  logic [15:0] r_start, r_end, r_step, r_interval, r_cur, r_tgt, r_cnt;
  logic        w_own, w_pwm, w_cpu_hit, w_wr, w_en_ok, w_grant, w_dn_ok;
  logic [7:0]  w_off;
  logic [15:0] w_step, w_wait, w_next;
  logic [16:0] w_up;
  logic [31:0] w_reg;
  logic        w_unused;
  assign w_unused  = &{1'b0, cpu_mem_wdata[31:16]};
  assign w_own     = cpu_mem_addr[31:8] == RAMP_BASE_ADDR[31:8];
  assign w_pwm     = cpu_mem_addr[31:8] == PWM_BASE_ADDR[31:8];
  assign w_cpu_hit = w_pwm && (cpu_mem_we || cpu_mem_re);
  assign w_off     = cpu_mem_addr[7:0];
  assign w_wr      = w_own && cpu_mem_we;
  assign w_en_ok   = cpu_mem_wdata[0] && ({1'b0, cpu_mem_wdata[7:4]} < CH_LIM);
  assign w_grant   = r_state == WRITE && !w_cpu_hit;
  assign w_step    = r_step == 16'd0 ? 16'd1 : r_step;
  assign w_wait    = r_interval == 16'd0 ? 16'd1 : r_interval;
  // step arithmetic is widened / guarded so it clamps to tgt instead of wrapping
  assign w_up      = {1'b0, r_cur} + {1'b0, w_step};
  assign w_dn_ok   = r_cur >= w_step && (r_cur - w_step) >= r_tgt;
  assign w_next    = r_dir ? (w_up > {1'b0, r_tgt} ? r_tgt : w_up[15:0])
                           : (w_dn_ok ? r_cur - w_step : r_tgt);
  assign pwm_mem_addr  = w_grant ? PWM_BASE_ADDR + {24'b0, r_ch, 4'h8} : cpu_mem_addr;
  assign pwm_mem_wdata = w_grant ? {16'b0, r_cur} : cpu_mem_wdata;
  assign pwm_mem_we    = w_grant || (cpu_mem_we && w_cpu_hit);
  assign pwm_mem_re    = cpu_mem_re && w_cpu_hit;
  assign done_irq      = r_done_irq;
  assign w_reg = w_off == 8'h00 ? {24'b0, r_ch, 2'b0, r_bounce, r_en} :
                 w_off == 8'h04 ? {16'b0, r_start} :
                 w_off == 8'h08 ? {16'b0, r_end} :
                 w_off == 8'h0C ? {16'b0, r_step} :
                 w_off == 8'h10 ? {16'b0, r_interval} :
                 w_off == 8'h14 ? {r_cur, 14'b0, r_done, r_state != IDLE} : 32'd0;
  assign cpu_mem_rdata = !cpu_mem_re ? 32'd0 : w_own ? w_reg : w_pwm ? pwm_mem_rdata : 32'd0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_en       <= 1'b0;
      r_bounce   <= 1'b0;
      r_ch       <= 4'd0;
      r_start    <= 16'd0;
      r_end      <= 16'd0;
      r_step     <= 16'd1;
      r_interval <= 16'd0;
      r_cur      <= 16'd0;
      r_tgt      <= 16'd0;
      r_cnt      <= 16'd0;
      r_dir      <= 1'b1;
      r_to_end   <= 1'b1;
      r_done     <= 1'b0;
      r_done_irq <= 1'b0;
    end else begin
      r_done_irq <= 1'b0;
      if (w_wr && w_off == 8'h04) r_start <= cpu_mem_wdata[15:0];
      if (w_wr && w_off == 8'h08) r_end <= cpu_mem_wdata[15:0];
      if (w_wr && w_off == 8'h0C) r_step <= cpu_mem_wdata[15:0];
      if (w_wr && w_off == 8'h10) r_interval <= cpu_mem_wdata[15:0];
      if (w_wr && w_off == 8'h00) begin
        r_bounce <= cpu_mem_wdata[1];
        r_ch     <= cpu_mem_wdata[7:4];
        r_en     <= w_en_ok;
        r_state  <= w_en_ok ? WRITE : IDLE;
        if (w_en_ok) begin
          r_cur    <= r_start;
          r_tgt    <= r_end;
          r_dir    <= r_end >= r_start;
          r_to_end <= 1'b1;
          r_done   <= 1'b0;
        end
      end else begin
        case (r_state)
          WRITE: if (w_grant) begin
            if (r_cur != r_tgt || r_bounce) begin
              r_cnt   <= w_wait;
              r_state <= WAIT;
            end else begin
              r_done_irq <= 1'b1;
              r_state    <= DONE;
            end
            if (r_cur == r_tgt && r_bounce) begin
              r_tgt    <= r_to_end ? r_start : r_end;
              r_to_end <= !r_to_end;
              r_dir    <= !r_dir;
            end
          end
          WAIT: begin
            r_cnt <= r_cnt - 16'd1;
            if (r_cnt <= 16'd1) begin
              r_cur   <= w_next;
              r_state <= WRITE;
            end
          end
          DONE: begin
            r_done  <= 1'b1;
            r_en    <= 1'b0;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule
